// File: rtl/instruction_memory_loader.sv
// Instruction store for the fetch stage, with a streaming flash loader.
// Fetch reads are only accepted in IDLE and flash writes only happen in FLASH, so the two never collide.
module instruction_memory_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              FlashStart,
  input  logic              FlashValid,
  input  logic              FlashLast,
  input  logic [DATA_W-1:0] FlashData,
  output logic              FlashBusy,
  output logic              FlashDone,
  output logic              FlashOverflow,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [ADDR_W-1:0] ReqAddr,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [DATA_W-1:0] RespData,
  output logic              RespFault
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, FLASH = 1'b1} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  wr_ptr, ptr_next;
  logic              ovf_next, done_next, wr_en;
  logic              req_fire, addr_ok;
  logic              vld_p1, fault_p1;
  logic [DATA_W-1:0] data_p1;
  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_next = state;
    ptr_next   = wr_ptr;
    ovf_next   = FlashOverflow;
    done_next  = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (FlashStart) begin
          state_next = FLASH;
          ptr_next   = '0;
          ovf_next   = 1'b0;
        end
      end
      FLASH: begin
        // A restart takes priority and drops any word offered in the same cycle.
        if (FlashStart) begin
          ptr_next = '0;
          ovf_next = 1'b0;
        end else if (FlashValid) begin
          wr_en = 1'b1;
          if (wr_ptr == LAST_IDX) begin
            ptr_next = '0;
            ovf_next = 1'b1;
          end else begin
            ptr_next = wr_ptr + 1'b1;
          end
          if (FlashLast) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      FlashOverflow <= 1'b0;
      FlashDone     <= 1'b0;
    end else if (clk_en) begin
      state         <= state_next;
      wr_ptr        <= ptr_next;
      FlashOverflow <= ovf_next;
      FlashDone     <= done_next;
    end else begin
      FlashDone     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && wr_en) mem[wr_ptr] <= FlashData;
  end

  // Request accept -> p1: registered read, held while the consumer stalls.
  assign ReqReady = rst_n && clk_en && (state == IDLE) && (!vld_p1 || RespReady);
  assign req_fire = ReqValid && ReqReady;
  assign addr_ok  = {1'b0, ReqAddr} < DEPTH_EXT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      fault_p1 <= 1'b0;
    end else if (clk_en) begin
      if (req_fire) begin
        vld_p1   <= 1'b1;
        data_p1  <= addr_ok ? mem[ReqAddr[IDX_W-1:0]] : '0;
        fault_p1 <= !addr_ok;
      end else if (RespReady) begin
        vld_p1   <= 1'b0;
      end
    end
  end

  assign FlashBusy = (state == FLASH);
  assign RespValid = vld_p1;
  assign RespData  = data_p1;
  assign RespFault = fault_p1;

endmodule
